dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path and an external requester (debug/DMA loader). It serializes accesses, drives the memory for a fixed `MEM_LAT` cycles per access, and returns a one-cycle acknowledge to the granted port. It also produces the CPU stall that freezes the PC and pipeline while a CPU access is outstanding.

## Interface
Parameters:
- `DATA_W`, default 32: data width.
- `ADDR_W`, default 32: address width.
- `MEM_LAT`, default 2: memory busy cycles per access; legal range 1..15.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `cpu_req_i` input 1: CPU request, level. Held with stable qualifiers until ack.
- `cpu_we_i` input 1: CPU write (1) / read (0).
- `cpu_addr_i` input `ADDR_W`: CPU address.
- `cpu_wdata_i` input `DATA_W`: CPU write data.
- `cpu_rdata_o` output `DATA_W`: read data; valid when `cpu_ack_o`=1.
- `cpu_ack_o` output 1: one-cycle completion pulse for the CPU port.
- `cpu_stall_o` output 1: `cpu_req_i & ~cpu_ack_o`, combinational.
- `ext_req_i`, `ext_we_i`, `ext_addr_i`, `ext_wdata_i`, `ext_rdata_o`, `ext_ack_o`: same as the CPU set, for the external port.
- `mem_en_o` output 1: memory access enable.
- `mem_we_o` output 1: memory write enable.
- `mem_addr_o` output `ADDR_W`: memory address.
- `mem_wdata_o` output `DATA_W`: memory write data.
- `mem_rdata_i` input `DATA_W`: memory read data.

## Operation
State machine:
- **IDLE**
  - No request → stay.
  - One request → grant it.
  - Both requesting → round-robin; the port not granted last wins.
  - `last_grant` resets to EXT, so the CPU wins the first tie.
  - On grant, register the granted port id, `we`, `addr` and `wdata`; load the counter with `MEM_LAT-1`; go to BUSY.
- **BUSY**
  - `mem_en_o`=1 on every BUSY cycle; `mem_we_o` = registered `we`.
  - `mem_addr_o` and `mem_wdata_o` come from the registered values.
  - Counter decrements each cycle.
  - At count 0: capture `mem_rdata_i` into the read-data register (reads only; writes leave it unchanged), update `last_grant`, go to ACK.
- **ACK**
  - The granted port's ack = 1 for exactly one cycle; the other ack = 0.
  - Requests are ignored; next state is IDLE.
  - The requester drops `req` or presents a new transaction at the edge that ends ACK.
- Outside BUSY, `mem_en_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are 0.
- `cpu_rdata_o` and `ext_rdata_o` both carry the shared read-data register.
- Counter width is 4 bits; it never wraps (reloaded on every grant).

## Timing
- Reset values: state IDLE; all acks 0; all `mem_*` outputs 0; read-data register 0; counter 0; `last_grant` = EXT.
- Latency: request sampled in IDLE at edge E0 → BUSY for `MEM_LAT` cycles → ack high during cycle `MEM_LAT+1` after E0.
- Sustained throughput: one access per `MEM_LAT+2` cycles (IDLE + BUSY + ACK).
- A request arriving during BUSY or ACK waits; it is sampled at the next IDLE.
- Simultaneous requests in IDLE are resolved by the arbitration rule in Operation; there is never a double grant.
- Reset mid-operation:
  - Asserting `rst_i` low forces all outputs to their reset values immediately; the in-flight access is dropped and no ack is given.
  - A request still held at release is re-granted from IDLE.
- Requester changing qualifiers while waiting is illegal; qualifiers are sampled only at grant.

## Configuration
- `DMEM_ARB_CPU_PRIORITY_EN` defined: fixed priority, CPU always wins ties; `last_grant` is unused; the external port may starve while the CPU requests continuously.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset: drive `rst_i`=0 with both requests high → all acks and `mem_*` outputs 0; after release, CPU granted first.
- CPU write then read, `MEM_LAT`=2:
  - Write `0xDEADBEEF` to `0x10` → `mem_we_o` high 2 cycles, `cpu_ack_o` in cycle 3 after sampling.
  - Read `0x10` → `cpu_rdata_o`=`0xDEADBEEF` with ack.
- Both requests held, round-robin → grant order C,E,C,E over 4 transactions; each ack exactly 4 cycles apart.
- With `DMEM_ARB_CPU_PRIORITY_EN`, both held → 4 CPU acks, 0 ext acks; drop `cpu_req_i` → ext acked 3 cycles after its sampling.
- Reset in second BUSY cycle of an ext write → `mem_en_o` 0 immediately, no ack; release with `ext_req_i` held → write reissued and acked.
- `cpu_stall_o` → high from `cpu_req_i` rise through the last BUSY cycle; low in the ACK cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: serialises CPU and external accesses onto one memory port.
// Define DMEM_ARB_CPU_PRIORITY_EN for fixed CPU priority instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              ext_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e            state_q, state_d;
  logic              gnt_ext_q, gnt_ext_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pick_ext;
  logic              busy;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  assign pick_ext = ext_req_i & ~cpu_req_i;
`else
  // last_ext_q resets to 1 so the CPU wins the first tie.
  logic last_ext_q, last_ext_d;
  assign pick_ext = ext_req_i & (~cpu_req_i | ~last_ext_q);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_ext_d = gnt_ext_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
    last_ext_d = last_ext_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_req_i || ext_req_i) begin
          state_d   = StBusy;
          gnt_ext_d = pick_ext;
          we_d      = pick_ext ? ext_we_i    : cpu_we_i;
          addr_d    = pick_ext ? ext_addr_i  : cpu_addr_i;
          wdata_d   = pick_ext ? ext_wdata_i : cpu_wdata_i;
          cnt_d     = CntInit;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
          if (!we_q) rdata_d = mem_rdata_i;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
          last_ext_d = gnt_ext_q;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      gnt_ext_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= 4'd0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      last_ext_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_ext_q <= gnt_ext_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      last_ext_q <= last_ext_d;
`endif
    end
  end

  assign busy        = (state_q == StBusy);
  assign mem_en_o    = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = busy ? addr_q  : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;

  assign cpu_ack_o   = (state_q == StAck) & ~gnt_ext_q;
  assign ext_ack_o   = (state_q == StAck) & gnt_ext_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  assign cpu_rdata_o = rdata_q;
  assign ext_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and an expected-ack scoreboard.
module tb_dmem_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_we_i, ext_req_i, ext_we_i;
  logic [AW-1:0] cpu_addr_i, ext_addr_i, mem_addr_o;
  logic [DW-1:0] cpu_wdata_i, ext_wdata_i, cpu_rdata_o, ext_rdata_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          cpu_ack_o, ext_ack_o, cpu_stall_o, mem_en_o, mem_we_o;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_ack_o  (cpu_ack_o),
    .cpu_stall_o(cpu_stall_o),
    .ext_req_i  (ext_req_i),
    .ext_we_i   (ext_we_i),
    .ext_addr_i (ext_addr_i),
    .ext_wdata_i(ext_wdata_i),
    .ext_rdata_o(ext_rdata_o),
    .ext_ack_o  (ext_ack_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem_arr [0:255];
  always @(posedge clk) if (mem_en_o && mem_we_o) mem_arr[mem_addr_o[7:0]] <= mem_wdata_o;
  assign mem_rdata_i = mem_arr[mem_addr_o[7:0]];

  typedef struct {
    logic          is_ext;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   last_ack_cyc = 0;
  int   c0;
  logic got_ext;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_ext, input logic [DW-1:0] rdata);
    exp_t e;
    e.is_ext = is_ext;
    e.rdata  = rdata;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next ack, pops the scoreboard and compares.
  task automatic take_ack(input int exp_gap, output logic ack_ext);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!(cpu_ack_o || ext_ack_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", 64'(cpu_ack_o | ext_ack_o), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    ack_ext = ext_ack_o;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ack_ext", 64'(ext_ack_o), 64'(e.is_ext));
      check("ack_cpu", 64'(cpu_ack_o), 64'(!e.is_ext));
      check("cpu_rdata", 64'(cpu_rdata_o), 64'(e.rdata));
      check("ext_rdata", 64'(ext_rdata_o), 64'(e.rdata));
    end
    check("ack_mem_en", 64'(mem_en_o), 64'd0);
    if (exp_gap != 0) check("ack_gap", 64'(cyc - last_ack_cyc), 64'(exp_gap));
    last_ack_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i       = 1'b0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 32'h10;
    cpu_wdata_i = 32'hDEADBEEF;
    ext_req_i   = 1'b1;
    ext_we_i    = 1'b1;
    ext_addr_i  = 32'h20;
    ext_wdata_i = 32'h12345678;
    repeat (2) @(negedge clk);

    // Reset with both ports requesting
    check("rst_cpu_ack", 64'(cpu_ack_o), 64'd0);
    check("rst_ext_ack", 64'(ext_ack_o), 64'd0);
    check("rst_mem_en", 64'(mem_en_o), 64'd0);
    check("rst_mem_we", 64'(mem_we_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_rdata", 64'(cpu_rdata_o), 64'd0);
    check("rst_stall", 64'(cpu_stall_o), 64'd1);

    rst_i = 1'b1;
    c0    = cyc;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    push(1'b0, 32'h0);
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'hDEADBEEF);
    push(1'b1, 32'h12345678);
`else
    push(1'b0, 32'h0);
    push(1'b1, 32'h0);
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'h12345678);
`endif

    @(negedge clk);
    check("b1_mem_en", 64'(mem_en_o), 64'd1);
    check("b1_mem_we", 64'(mem_we_o), 64'd1);
    check("b1_mem_addr", 64'(mem_addr_o), 64'h10);
    check("b1_mem_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
    check("b1_stall", 64'(cpu_stall_o), 64'd1);
    @(negedge clk);
    check("b2_mem_en", 64'(mem_en_o), 64'd1);
    check("b2_mem_we", 64'(mem_we_o), 64'd1);
    check("b2_stall", 64'(cpu_stall_o), 64'd1);
    check("b2_cpu_ack", 64'(cpu_ack_o), 64'd0);

    // Four back-to-back transactions; each port turns write into read, then drops.
    for (int i = 0; i < 4; i++) begin
      take_ack((i == 0) ? 0 : 4, got_ext);
      if (i == 0) begin
        check("first_latency", 64'(cyc - c0), 64'd3);
        check("ack_stall_low", 64'(cpu_stall_o), 64'd0);
      end
      if (!got_ext) begin
        if (cpu_we_i) cpu_we_i = 1'b0;
        else cpu_req_i = 1'b0;
      end else begin
        if (ext_we_i) ext_we_i = 1'b0;
        else ext_req_i = 1'b0;
      end
    end
    check("sb_empty_a", 64'(sb.size()), 64'd0);

    // Stall window for a CPU read of the word the external port wrote
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h20;
    push(1'b0, 32'h12345678);
    #1;
    check("stall_rise", 64'(cpu_stall_o), 64'd1);
    @(negedge clk);
    check("stall_busy1", 64'(cpu_stall_o), 64'd1);
    @(negedge clk);
    check("stall_busy2", 64'(cpu_stall_o), 64'd1);
    take_ack(0, got_ext);
    check("stall_ack", 64'(cpu_stall_o), 64'd0);
    cpu_req_i = 1'b0;

    // Reset during the second BUSY cycle of an external write
    @(negedge clk);
    ext_req_i   = 1'b1;
    ext_we_i    = 1'b1;
    ext_addr_i  = 32'h30;
    ext_wdata_i = 32'hA5A5A5A5;
    @(negedge clk);
    check("mr_busy1_en", 64'(mem_en_o), 64'd1);
    check("mr_busy1_addr", 64'(mem_addr_o), 64'h30);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("mr_en", 64'(mem_en_o), 64'd0);
    check("mr_we", 64'(mem_we_o), 64'd0);
    check("mr_addr", 64'(mem_addr_o), 64'd0);
    check("mr_rdata", 64'(ext_rdata_o), 64'd0);
    @(negedge clk);
    check("mr_no_ack", 64'(ext_ack_o), 64'd0);
    check("mr_en_held", 64'(mem_en_o), 64'd0);
    rst_i = 1'b1;
    c0    = cyc;
    push(1'b1, 32'h0);
    take_ack(0, got_ext);
    check("mr_reissue_latency", 64'(cyc - c0), 64'd3);
    ext_req_i = 1'b0;

    // Confirm the reissued write landed
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h30;
    push(1'b0, 32'hA5A5A5A5);
    take_ack(0, got_ext);
    cpu_req_i = 1'b0;
    check("sb_empty_end", 64'(sb.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
